// File: rtl/seq_div8_pkg.sv
// seq_div8_pkg: shared constants and state encoding for the sequential divider
package seq_div8_pkg;
  localparam int WIDTH = 8;
  localparam int LATENCY = WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/seq_div8_step.sv
// seq_div8_step: one combinational restoring-division step on magnitudes
module seq_div8_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] dvd,
  input  logic [W-1:0] dsr,
  output logic [W:0]   rem_nxt,
  output logic [W-1:0] dvd_nxt
);
  logic [W+1:0] sh;
  logic [W+1:0] trial;
  always_comb begin
    sh = {rem, dvd[W-1]};
    trial = sh - {2'b0, dsr};
    rem_nxt = trial[W+1] ? sh[W:0] : trial[W:0];
    dvd_nxt = {dvd[W-2:0], ~trial[W+1]};
  end
endmodule

// File: rtl/seq_div8.sv
// seq_div8: signed sequential restoring divider, truncating toward zero
module seq_div8
  import seq_div8_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] inp_a,
  input  logic [W-1:0] inp_b,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic         overflow
);
  localparam int CW = $clog2(W + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0] rem_q, rem_d, rem_nx;
  logic [W-1:0] dvd_q, dvd_d, dvd_nx, dsr_q, dsr_d, a_q, a_d;
  logic [W-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, ov_q, ov_d;

  seq_div8_step #(.W(W)) u_step (
    .rem(rem_q), .dvd(dvd_q), .dsr(dsr_q), .rem_nxt(rem_nx), .dvd_nxt(dvd_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    a_d = a_q;
    sq_d = sq_q;
    sr_d = sr_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dz_d = dz_q;
    ov_d = ov_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = start ? CALC : IDLE;
        if (start) begin
          a_d = inp_a;
          dvd_d = inp_a[W-1] ? -inp_a : inp_a;
          dsr_d = inp_b[W-1] ? -inp_b : inp_b;
          sq_d = inp_a[W-1] ^ inp_b[W-1];
          sr_d = inp_a[W-1];
          rem_d = '0;
          cnt_d = '0;
        end
      end
      CALC: begin
        rem_d = rem_nx;
        dvd_d = dvd_nx;
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(W - 1)) ? FIX : CALC;
      end
      FIX: begin
        dz_d = dsr_q == '0;
        // divisor sign is recovered as sign_q ^ sign_r
        ov_d = a_q == {1'b1, {(W-1){1'b0}}} && dsr_q == W'(1) && (sq_q ^ sr_q);
        quo_d = dz_d ? '1 : (sq_q ? -dvd_q : dvd_q);
        rmd_d = dz_d ? a_q : (sr_q ? -rem_q[W-1:0] : rem_q[W-1:0]);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
      a_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      quo_q <= '0;
      rmd_q <= '0;
      dz_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      a_q <= a_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      dz_q <= dz_d;
      ov_q <= ov_d;
    end
  end

  assign quotient = quo_q;
  assign remainder = rmd_q;
  assign busy = state_q == CALC || state_q == FIX;
  assign done = state_q == DONE;
  assign div_zero = dz_q;
  assign overflow = ov_q;
endmodule

// File: tb/tb_seq_div8.sv
// tb_seq_div8: directed self-checking bench for seq_div8
module tb_seq_div8;
  import seq_div8_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] inp_a = '0;
  logic [7:0] inp_b = '0;
  logic [7:0] quotient, remainder;
  logic busy, done, div_zero, overflow;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;
  int seen;

  seq_div8 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inp_a(inp_a), .inp_b(inp_b),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    inp_a = a;
    inp_b = b;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 30 && done !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, " done"}, {31'b0, done}, 1);
    chk({tag, " latency"}, cyc - c0, LATENCY);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                     input logic [7:0] er, input logic edz, input logic eov, input string tag);
    go(a, b);
    wait_done(tag);
    chk({tag, " quotient"}, {24'b0, quotient}, {24'b0, eq});
    chk({tag, " remainder"}, {24'b0, remainder}, {24'b0, er});
    chk({tag, " div_zero"}, {31'b0, div_zero}, {31'b0, edz});
    chk({tag, " overflow"}, {31'b0, overflow}, {31'b0, eov});
    chk({tag, " busy"}, {31'b0, busy}, 0);
    @(posedge clk);
    #1 chk({tag, " done drop"}, {31'b0, done}, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst quotient", {24'b0, quotient}, 0);
    chk("rst remainder", {24'b0, remainder}, 0);
    chk("rst flags", {28'b0, busy, done, div_zero, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, "100/7");
    run(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, "-100/7");
    run(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, "100/-7");
    run(8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, "-100/-7");
    run(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, "-128/-1");
    run(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, "-128/1");
    run(8'd127, 8'd127, 8'h01, 8'h00, 1'b0, 1'b0, "127/127");
    run(8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1'b0, "5/0");
    run(8'd6, 8'd3, 8'h02, 8'h00, 1'b0, 1'b0, "6/3");

    go(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    #1;
    inp_a = 8'd9;
    inp_b = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignored");
    chk("ignored quotient", {24'b0, quotient}, 32'h0E);
    chk("ignored remainder", {24'b0, remainder}, 32'h02);

    @(negedge clk);
    inp_a = 8'd50;
    inp_b = 8'd5;
    start = 1'b1;
    c0 = cyc;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      inp_a = 8'd9;
      inp_b = 8'd4;
      if (i == 10) begin
        chk("b2b done1", {31'b0, done}, 1);
        chk("b2b q1", {24'b0, quotient}, 32'd10);
        chk("b2b r1", {24'b0, remainder}, 32'd0);
      end
      if (i < 20) begin
        chk("b2b busy", {31'b0, busy}, (i == 10) ? 0 : 1);
        if (i != 10) chk("b2b no done", {31'b0, done}, 0);
      end else begin
        start = 1'b0;
        chk("b2b done2", {31'b0, done}, 1);
        chk("b2b q2", {24'b0, quotient}, 32'd2);
        chk("b2b r2", {24'b0, remainder}, 32'd1);
      end
    end

    go(8'd100, 8'd7);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort quotient", {24'b0, quotient}, 0);
    chk("abort remainder", {24'b0, remainder}, 0);
    chk("abort flags", {28'b0, busy, done, div_zero, overflow}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    chk("abort no done", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
